sram_device_responder: RTL and testbench

// Clocked, synthesizable device-side model of the 256K x 16 async SRAM that myARM's memory stage drives.

---
 rtl/sram_device_responder_if.sv | 27 ++
 rtl/sram_device_responder.sv | 92 +++++++++
 tb/tb_sram_device_responder.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_device_responder_if.sv
// Pin bundle of the 256K x 16 asynchronous SRAM as seen from the memory controller.
// dq_oe exposes the responder's per-lane output enables so bus ownership can be observed.
interface sram_device_responder_if #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
);
   wire  [DATA_W-1:0] dq;
   logic [ADDR_W-1:0] addr;
   logic              ub_n;
   logic              lb_n;
   logic              we_n;
   logic              ce_n;
   logic              oe_n;
   logic [1:0]        dq_oe;

   modport master (
      inout  dq,
      output addr, ub_n, lb_n, we_n, ce_n, oe_n,
      input  dq_oe
   );

   modport slave (
      inout  dq,
      input  addr, ub_n, lb_n, we_n, ce_n, oe_n,
      output dq_oe
   );
endinterface

// File: rtl/sram_device_responder.sv
// Device-side SRAM model: decodes the SRAM pins, stores written bytes and returns
// read data through a fixed-latency pipeline onto the tri-stated DQ bus.
module sram_device_responder #(
   parameter int    ADDR_W     = 18,
   parameter int    DATA_W     = 16,
   parameter int    DEPTH_LOG2 = 16,
   parameter int    RD_LAT     = 2,
   parameter string INIT_FILE  = ""
) (
   input  logic                    clk,
   input  logic                    rst_n,
   sram_device_responder_if.slave  bus,
   output logic [31:0]             rd_count,
   output logic [31:0]             wr_count,
   output logic                    proto_err
);

   localparam int HALF = DATA_W / 2;

   logic [DATA_W-1:0]     mem [0:(1 << DEPTH_LOG2) - 1];
   logic [DEPTH_LOG2-1:0] idx_s;
   logic                  unused_addr_hi_s;
   logic [1:0]            lane_s;
   logic                  cmd_act_s;
   logic                  is_wr_s;
   logic                  is_rd_s;
   logic                  out_vld_s;
   logic                  rd_gate_s;
   logic [1:0]            dq_oe_s;

   logic [RD_LAT-1:0]     pvld_r;
   logic [DATA_W-1:0]     pdat_r [RD_LAT];
   logic [1:0]            pmsk_r [RD_LAT];

   // Upper address bits alias onto the stored depth.
   assign idx_s            = bus.addr[DEPTH_LOG2-1:0];
   assign unused_addr_hi_s = ^bus.addr[ADDR_W-1:DEPTH_LOG2];

   assign lane_s    = {~bus.ub_n, ~bus.lb_n};
   assign cmd_act_s = ~bus.ce_n & (|lane_s);
   assign is_wr_s   = cmd_act_s & ~bus.we_n;
   assign is_rd_s   = cmd_act_s & bus.we_n & ~bus.oe_n;

   assign out_vld_s = pvld_r[RD_LAT-1];
   assign rd_gate_s = out_vld_s & ~bus.ce_n & bus.we_n & ~bus.oe_n;
   assign dq_oe_s   = {rd_gate_s, rd_gate_s} & pmsk_r[RD_LAT-1];

   // Drive gating follows the live pins so the bus is released the moment the controller turns it.
   assign bus.dq    = {dq_oe_s[1] ? pdat_r[RD_LAT-1][DATA_W-1:HALF] : {HALF{1'bz}},
                       dq_oe_s[0] ? pdat_r[RD_LAT-1][HALF-1:0]      : {HALF{1'bz}}};
   assign bus.dq_oe = dq_oe_s;

   // Array writes and read-data pipeline; data is only meaningful alongside pvld_r.
   always_ff @(posedge clk) begin
      if (is_wr_s) begin
         if (lane_s[0]) mem[idx_s][HALF-1:0]      <= bus.dq[HALF-1:0];
         if (lane_s[1]) mem[idx_s][DATA_W-1:HALF] <= bus.dq[DATA_W-1:HALF];
      end
      pdat_r[0] <= mem[idx_s];
      pmsk_r[0] <= lane_s;
      for (int i = 1; i < RD_LAT; i++) begin
         pdat_r[i] <= pdat_r[i-1];
         pmsk_r[i] <= pmsk_r[i-1];
      end
   end

   // Valid pipeline, saturating counters and sticky misuse flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pvld_r    <= '0;
         rd_count  <= 32'd0;
         wr_count  <= 32'd0;
         proto_err <= 1'b0;
      end else begin
         pvld_r[0] <= is_rd_s;
         for (int i = 1; i < RD_LAT; i++) begin
            pvld_r[i] <= pvld_r[i-1];
         end
         if (is_rd_s && (rd_count != 32'hFFFF_FFFF)) begin
            rd_count <= rd_count + 32'd1;
         end
         if (is_wr_s && (wr_count != 32'hFFFF_FFFF)) begin
            wr_count <= wr_count + 32'd1;
         end
         // Write with OE asserted, or controller writing while read data is due.
         if ((is_wr_s && !bus.oe_n) || (out_vld_s && !bus.we_n)) begin
            proto_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sram_device_responder.sv
// Randomized + directed bench: stimulus pushes expected read responses to a queue,
// a negedge monitor pops and checks DQ ownership and data against a byte-lane memory model.
module tb_sram_device_responder;

   localparam int RD_LAT = 2;

   typedef struct {
      int          due;
      logic [15:0] d;
      logic [1:0]  m;
   } rd_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic        proto_err;
   logic        tb_drv = 1'b0;
   logic [15:0] tb_wd = 16'h0000;

   always #5 clk = ~clk;

   sram_device_responder_if bus_if ();

   assign bus_if.dq = tb_drv ? tb_wd : 16'hzzzz;

   sram_device_responder #(.RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus_if),
      .rd_count  (rd_count),
      .wr_count  (wr_count),
      .proto_err (proto_err)
   );

   logic [15:0] mm [0:65535];
   int          m_rd = 0;
   int          m_wr = 0;
   bit          m_perr = 1'b0;
   rd_t         q[$];
   int          errs = 0;
   int          checks = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic ce, input logic we, input logic oe, input logic ub,
                        input logic lb, input logic [17:0] a, input logic [15:0] d);
      logic [15:0] idx;
      rd_t         e;
      @(posedge clk);
      #1;
      bus_if.ce_n = ce;
      bus_if.we_n = we;
      bus_if.oe_n = oe;
      bus_if.ub_n = ub;
      bus_if.lb_n = lb;
      bus_if.addr = a;
      tb_wd       = d;
      tb_drv      = !ce && !we;
      idx         = a[15:0];
      if (!ce && (!ub || !lb)) begin
         if (!we) begin
            if (!lb) mm[idx][7:0]  = d[7:0];
            if (!ub) mm[idx][15:8] = d[15:8];
            m_wr++;
            if (!oe) m_perr = 1'b1;
         end else if (!oe) begin
            e.due = cyc + RD_LAT;
            e.d   = mm[idx];
            e.m   = {!ub, !lb};
            q.push_back(e);
            m_rd++;
         end
      end
   endtask

   task automatic idle();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
      drive(1'b0, 1'b0, 1'b1, ub, lb, a, d);
   endtask

   task automatic rd(input logic [17:0] a, input logic ub, input logic lb);
      drive(1'b0, 1'b1, 1'b0, ub, lb, a, 16'h0);
   endtask

   task automatic settle(input string nm);
      repeat (RD_LAT + 2) idle();
      check({nm, "_rd"}, rd_count, m_rd);
      check({nm, "_wr"}, wr_count, m_wr);
      check({nm, "_perr"}, {31'd0, proto_err}, {31'd0, m_perr});
   endtask

   // Monitor: a due response must drive exactly the lanes the live pins allow; otherwise DQ is released.
   always @(negedge clk) begin : mon
      rd_t        h;
      logic [1:0] eo;
      if (rst_n) begin
         eo = 2'b00;
         while (q.size() > 0 && q[0].due < cyc) begin
            h = q.pop_front();
            check("stale_read", h.due, cyc);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            h = q.pop_front();
            if (!bus_if.ce_n && bus_if.we_n && !bus_if.oe_n) eo = h.m;
            if (!bus_if.we_n) m_perr = 1'b1;
            if (eo[0]) check("dq_lo", {24'd0, bus_if.dq[7:0]}, {24'd0, h.d[7:0]});
            if (eo[1]) check("dq_hi", {24'd0, bus_if.dq[15:8]}, {24'd0, h.d[15:8]});
         end
         check("dq_oe", {30'd0, bus_if.dq_oe}, {30'd0, eo});
      end
   end

   initial begin
      bus_if.ce_n = 1'b1;
      bus_if.we_n = 1'b1;
      bus_if.oe_n = 1'b1;
      bus_if.ub_n = 1'b1;
      bus_if.lb_n = 1'b1;
      bus_if.addr = 18'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rd", rd_count, 32'd0);
      check("rst_wr", wr_count, 32'd0);
      check("rst_perr", {31'd0, proto_err}, 32'd0);
      check("rst_oe", {30'd0, bus_if.dq_oe}, 32'd0);
      rst_n = 1'b1;

      wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
      rd(18'h00010, 1'b0, 1'b0);
      settle("beef");
      check("beef_wr1", wr_count, 32'd1);
      check("beef_rd1", rd_count, 32'd1);

      wr(18'h00005, 16'h1234, 1'b0, 1'b0);
      wr(18'h00005, 16'hAB00, 1'b0, 1'b1);
      rd(18'h00005, 1'b0, 1'b0);
      rd(18'h00005, 1'b1, 1'b0);
      settle("lanes");

      wr(18'h0, 16'h1111, 1'b0, 1'b0);
      wr(18'h1, 16'h2222, 1'b0, 1'b0);
      wr(18'h2, 16'h3333, 1'b0, 1'b0);
      rd(18'h0, 1'b0, 1'b0);
      rd(18'h1, 1'b0, 1'b0);
      rd(18'h2, 1'b0, 1'b0);
      settle("stream");

      wr(18'h20005, 16'hCAFE, 1'b0, 1'b0);
      rd(18'h00005, 1'b0, 1'b0);
      settle("alias");

      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h7, 16'h0F0F);
      rd(18'h7, 1'b0, 1'b0);
      settle("misuse");
      check("misuse_perr1", {31'd0, proto_err}, 32'd1);

      // Reset while a read is in flight: the response is dropped and the bus stays released.
      rd(18'h00010, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      m_rd   = 0;
      m_wr   = 0;
      m_perr = 1'b0;
      bus_if.ce_n = 1'b1;
      bus_if.oe_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_oe", {30'd0, bus_if.dq_oe}, 32'd0);
      check("mid_rst_rd", rd_count, 32'd0);
      check("mid_rst_perr", {31'd0, proto_err}, 32'd0);
      rst_n = 1'b1;
      rd(18'h00010, 1'b0, 1'b0);
      settle("post_rst");

      rd(18'h00010, 1'b0, 1'b0);
      idle();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0);
      settle("contend");
      check("contend_perr1", {31'd0, proto_err}, 32'd1);

      for (int i = 0; i < 16; i++) wr(18'(i), 16'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom),
               {2'($urandom), 12'h000, 4'($urandom)}, 16'($urandom));
      end
      settle("random");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
